// File: rtl/rvh_l1d_pkg.sv
// rtl/rvh_l1d_pkg.sv - L1D AMO executor types, STU opcode encodings and decode helpers
package rvh_l1d_pkg;

    localparam int L1D_DATA_W     = 64;
    localparam int L1D_ADDR_W     = 56;
    localparam int L1D_ROB_TAG_W  = 7;
    localparam int L1D_PREG_TAG_W = 7;
    localparam int L1D_OP_W       = 6;

    // STU opcodes: every word (W) variant has an odd code, doubleword (D) an even one.
    localparam logic [L1D_OP_W-1:0] STU_LRW      = 6'h01;
    localparam logic [L1D_OP_W-1:0] STU_LRD      = 6'h02;
    localparam logic [L1D_OP_W-1:0] STU_SCW      = 6'h03;
    localparam logic [L1D_OP_W-1:0] STU_SCD      = 6'h04;
    localparam logic [L1D_OP_W-1:0] STU_AMOSWAPW = 6'h05;
    localparam logic [L1D_OP_W-1:0] STU_AMOSWAPD = 6'h06;
    localparam logic [L1D_OP_W-1:0] STU_AMOADDW  = 6'h07;
    localparam logic [L1D_OP_W-1:0] STU_AMOADDD  = 6'h08;
    localparam logic [L1D_OP_W-1:0] STU_AMOANDW  = 6'h09;
    localparam logic [L1D_OP_W-1:0] STU_AMOANDD  = 6'h0A;
    localparam logic [L1D_OP_W-1:0] STU_AMOORW   = 6'h0B;
    localparam logic [L1D_OP_W-1:0] STU_AMOORD   = 6'h0C;
    localparam logic [L1D_OP_W-1:0] STU_AMOXORW  = 6'h0D;
    localparam logic [L1D_OP_W-1:0] STU_AMOXORD  = 6'h0E;
    localparam logic [L1D_OP_W-1:0] STU_AMOMAXW  = 6'h0F;
    localparam logic [L1D_OP_W-1:0] STU_AMOMAXD  = 6'h10;
    localparam logic [L1D_OP_W-1:0] STU_AMOMAXUW = 6'h11;
    localparam logic [L1D_OP_W-1:0] STU_AMOMAXUD = 6'h12;
    localparam logic [L1D_OP_W-1:0] STU_AMOMINW  = 6'h13;
    localparam logic [L1D_OP_W-1:0] STU_AMOMIND  = 6'h14;
    localparam logic [L1D_OP_W-1:0] STU_AMOMINUW = 6'h15;
    localparam logic [L1D_OP_W-1:0] STU_AMOMINUD = 6'h16;

    typedef enum logic [2:0] {
        AMO_S_IDLE    = 3'd0,
        AMO_S_RD_REQ  = 3'd1,
        AMO_S_RD_WAIT = 3'd2,
        AMO_S_CALC    = 3'd3,
        AMO_S_WR_REQ  = 3'd4,
        AMO_S_RESP    = 3'd5
    } l1d_amo_exec_fsm_t;

    typedef enum logic [3:0] {
        AMO_ALU_SWAP, AMO_ALU_ADD, AMO_ALU_AND, AMO_ALU_OR, AMO_ALU_XOR,
        AMO_ALU_MAX, AMO_ALU_MAXU, AMO_ALU_MIN, AMO_ALU_MINU
    } l1d_amo_alu_op_t;

    typedef struct packed {
        logic [L1D_ROB_TAG_W-1:0]  rob_tag;
        logic [L1D_PREG_TAG_W-1:0] prd;
        logic [L1D_OP_W-1:0]       opcode;
        logic [L1D_ADDR_W-1:0]     paddr;
        logic [L1D_DATA_W-1:0]     data;
        logic                      sc_succ;
        logic                      is_lr;
        logic                      is_sc;
        logic                      is_word;
    } l1d_amo_exec_req_t;

    function automatic logic decode_is_word(input logic [L1D_OP_W-1:0] opcode);
        return opcode[0];
    endfunction

    function automatic logic decode_is_lr(input logic [L1D_OP_W-1:0] opcode);
        return (opcode == STU_LRW) || (opcode == STU_LRD);
    endfunction

    function automatic logic decode_is_sc(input logic [L1D_OP_W-1:0] opcode);
        return (opcode == STU_SCW) || (opcode == STU_SCD);
    endfunction

    // LR and SC map to SWAP: LR never writes, and an SC writes rs2 exactly like a swap.
    function automatic l1d_amo_alu_op_t decode_alu_op(input logic [L1D_OP_W-1:0] opcode);
        case (opcode)
            STU_AMOADDW,  STU_AMOADDD:  return AMO_ALU_ADD;
            STU_AMOANDW,  STU_AMOANDD:  return AMO_ALU_AND;
            STU_AMOORW,   STU_AMOORD:   return AMO_ALU_OR;
            STU_AMOXORW,  STU_AMOXORD:  return AMO_ALU_XOR;
            STU_AMOMAXW,  STU_AMOMAXD:  return AMO_ALU_MAX;
            STU_AMOMAXUW, STU_AMOMAXUD: return AMO_ALU_MAXU;
            STU_AMOMINW,  STU_AMOMIND:  return AMO_ALU_MIN;
            STU_AMOMINUW, STU_AMOMINUD: return AMO_ALU_MINU;
            default:                    return AMO_ALU_SWAP;
        endcase
    endfunction

endpackage

// File: rtl/rvh_l1d_amo_alu.sv
// rtl/rvh_l1d_amo_alu.sv - combinational AMO modify stage for word and doubleword ops
module rvh_l1d_amo_alu
    import rvh_l1d_pkg::*;
(
    input  l1d_amo_alu_op_t         op,
    input  logic                    is_word,
    input  logic [L1D_DATA_W-1:0]   old,
    input  logic [L1D_DATA_W-1:0]   rs2,
    output logic [L1D_DATA_W-1:0]   new_data
);
    logic [L1D_DATA_W-1:0] a, b, res;

    // Word ops run on sign-extended 32-bit operands: sign extension preserves both
    // signed and unsigned order, so one 64-bit datapath serves both widths.
    always_comb begin
        a   = is_word ? {{32{old[31]}}, old[31:0]} : old;
        b   = is_word ? {{32{rs2[31]}}, rs2[31:0]} : rs2;
        res = b;
        case (op)
            AMO_ALU_SWAP: res = b;
            AMO_ALU_ADD:  res = a + b;
            AMO_ALU_AND:  res = a & b;
            AMO_ALU_OR:   res = a | b;
            AMO_ALU_XOR:  res = a ^ b;
            AMO_ALU_MAX:  res = ($signed(a) >= $signed(b)) ? a : b;
            AMO_ALU_MAXU: res = (a >= b) ? a : b;
            AMO_ALU_MIN:  res = ($signed(a) <= $signed(b)) ? a : b;
            AMO_ALU_MINU: res = (a <= b) ? a : b;
            default:      res = b;
        endcase
        new_data = is_word ? {2{res[31:0]}} : res;
    end
endmodule

// File: rtl/std_dffe.sv
// rtl/std_dffe.sv - enable flop and enable flop with synchronous active-low reset
module std_dffe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Load d when enabled; no reset, contents qualified by the owner's state.
    always_ff @(posedge clk) begin
        if (en) q <= d;
    end
endmodule

module std_dffrve #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] rst_val,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Synchronous reset to rst_val, otherwise load d when enabled.
    always_ff @(posedge clk) begin
        if (!rstn)   q <= rst_val;
        else if (en) q <= d;
    end
endmodule

// File: rtl/rvh_l1d_amo_exec.sv
// rtl/rvh_l1d_amo_exec.sv - LR/SC/AMO read-modify-write executor; option RVH_L1D_AMO_MISALIGN_CHK_EN
module rvh_l1d_amo_exec
    import rvh_l1d_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 56,
    parameter int ROB_TAG_W  = 7,
    parameter int PREG_TAG_W = 7,
    parameter int OP_W       = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  amo_req_vld_i,
    output logic                  amo_req_rdy_o,
    input  logic [ROB_TAG_W-1:0]  amo_req_rob_tag_i,
    input  logic [PREG_TAG_W-1:0] amo_req_prd_i,
    input  logic [OP_W-1:0]       amo_req_opcode_i,
    input  logic [ADDR_W-1:0]     amo_req_paddr_i,
    input  logic [DATA_W-1:0]     amo_req_data_i,
    input  logic                  amo_req_sc_succ_i,
    output logic                  bank_rd_vld_o,
    input  logic                  bank_rd_rdy_i,
    output logic [ADDR_W-1:0]     bank_rd_addr_o,
    input  logic                  bank_rd_resp_vld_i,
    input  logic [DATA_W-1:0]     bank_rd_resp_data_i,
    output logic                  bank_wr_vld_o,
    input  logic                  bank_wr_rdy_i,
    output logic [ADDR_W-1:0]     bank_wr_addr_o,
    output logic [DATA_W-1:0]     bank_wr_data_o,
    output logic [DATA_W/8-1:0]   bank_wr_mask_o,
    output logic                  rob_wb_vld_o,
    output logic [ROB_TAG_W-1:0]  rob_wb_rob_tag_o,
    output logic [PREG_TAG_W-1:0] rob_wb_prd_o,
    output logic [DATA_W-1:0]     rob_wb_data_o
`ifdef RVH_L1D_AMO_MISALIGN_CHK_EN
    ,
    output logic                  rob_wb_excp_o
`endif
);
    l1d_amo_exec_fsm_t                    state_q, state_d;
    logic [$bits(l1d_amo_exec_fsm_t)-1:0] state_raw;
    l1d_amo_exec_req_t                    req_d, req_q;
    logic [DATA_W-1:0]                    rd_data_q, old_q, new_q, old_ext, calc_wb, alu_new, wb_data;
    logic [31:0]                          old_lane;
    logic [ADDR_W-1:0]                    dw_addr;
    logic [DATA_W/8-1:0]                  wr_mask;
    logic                                 req_hs, sc_fail_in, unused_paddr_lo;

    assign req_hs          = amo_req_vld_i & amo_req_rdy_o;
    assign sc_fail_in      = decode_is_sc(amo_req_opcode_i) & ~amo_req_sc_succ_i;
    assign unused_paddr_lo = ^req_q.paddr[1:0];

    // Latch the request with its decoded class so later states never look at the inputs.
    always_comb begin
        req_d         = '0;
        req_d.rob_tag = amo_req_rob_tag_i;
        req_d.prd     = amo_req_prd_i;
        req_d.opcode  = amo_req_opcode_i;
        req_d.paddr   = amo_req_paddr_i;
        req_d.data    = amo_req_data_i;
        req_d.sc_succ = amo_req_sc_succ_i;
        req_d.is_lr   = decode_is_lr(amo_req_opcode_i);
        req_d.is_sc   = decode_is_sc(amo_req_opcode_i);
        req_d.is_word = decode_is_word(amo_req_opcode_i);
    end

    std_dffrve #(.WIDTH($bits(l1d_amo_exec_fsm_t))) u_state_reg (
        .clk(clk), .rstn(rst), .rst_val(AMO_S_IDLE), .en(1'b1), .d(state_d), .q(state_raw));
    assign state_q = l1d_amo_exec_fsm_t'(state_raw);

    std_dffe #(.WIDTH($bits(l1d_amo_exec_req_t))) u_req_reg (
        .clk(clk), .en(req_hs), .d(req_d), .q(req_q));
    std_dffe #(.WIDTH(DATA_W)) u_rd_data_reg (
        .clk(clk), .en((state_q == AMO_S_RD_WAIT) & bank_rd_resp_vld_i),
        .d(bank_rd_resp_data_i), .q(rd_data_q));
    std_dffe #(.WIDTH(DATA_W)) u_old_reg (
        .clk(clk), .en(state_q == AMO_S_CALC), .d(calc_wb), .q(old_q));
    std_dffe #(.WIDTH(DATA_W)) u_new_reg (
        .clk(clk), .en(state_q == AMO_S_CALC), .d(alu_new), .q(new_q));

`ifdef RVH_L1D_AMO_MISALIGN_CHK_EN
    logic misalign_in, misalign_q;
    assign misalign_in = decode_is_word(amo_req_opcode_i) ? (amo_req_paddr_i[1:0] != 2'b00)
                                                          : (amo_req_paddr_i[2:0] != 3'b000);
    // A failed SC keeps its normal status response even when misaligned.
    std_dffe #(.WIDTH(1)) u_misalign_reg (
        .clk(clk), .en(req_hs), .d(misalign_in & ~sc_fail_in), .q(misalign_q));
`endif

    // Old value seen by the ALU and returned to the ROB: the addressed lane, sign-extended, for W ops.
    assign old_lane = req_q.paddr[2] ? rd_data_q[63:32] : rd_data_q[31:0];
    assign old_ext  = req_q.is_word ? {{32{old_lane[31]}}, old_lane} : rd_data_q;
    assign calc_wb  = req_q.is_sc ? '0 : old_ext;

    rvh_l1d_amo_alu u_alu (
        .op(decode_alu_op(req_q.opcode)), .is_word(req_q.is_word),
        .old(old_ext), .rs2(req_q.data), .new_data(alu_new));

    // Next-state logic; SC failure (and misalignment when checked) skips the bank entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            AMO_S_IDLE: begin
                if (req_hs) begin
                    state_d = AMO_S_RD_REQ;
                    if (sc_fail_in) state_d = AMO_S_RESP;
`ifdef RVH_L1D_AMO_MISALIGN_CHK_EN
                    if (misalign_in) state_d = AMO_S_RESP;
`endif
                end
            end
            AMO_S_RD_REQ:  if (bank_rd_rdy_i) state_d = AMO_S_RD_WAIT;
            AMO_S_RD_WAIT: if (bank_rd_resp_vld_i) state_d = AMO_S_CALC;
            AMO_S_CALC:    state_d = req_q.is_lr ? AMO_S_RESP : AMO_S_WR_REQ;
            AMO_S_WR_REQ:  if (bank_wr_rdy_i) state_d = AMO_S_RESP;
            AMO_S_RESP:    state_d = AMO_S_IDLE;
            default:       state_d = AMO_S_IDLE;
        endcase
    end

    // Writeback payload: SC status, misalignment zero, or the registered old value.
    always_comb begin
        wb_data = old_q;
        if (req_q.is_sc && !req_q.sc_succ) wb_data = DATA_W'(1);
`ifdef RVH_L1D_AMO_MISALIGN_CHK_EN
        if (misalign_q) wb_data = '0;
`endif
    end

    assign dw_addr = {req_q.paddr[ADDR_W-1:3], 3'b000};
    assign wr_mask = !req_q.is_word ? 8'hFF : (req_q.paddr[2] ? 8'hF0 : 8'h0F);

    // Outputs are qualified by state so that every payload reads zero outside its handshake.
    assign amo_req_rdy_o    = (state_q == AMO_S_IDLE);
    assign bank_rd_vld_o    = (state_q == AMO_S_RD_REQ);
    assign bank_rd_addr_o   = bank_rd_vld_o ? dw_addr : '0;
    assign bank_wr_vld_o    = (state_q == AMO_S_WR_REQ);
    assign bank_wr_addr_o   = bank_wr_vld_o ? dw_addr : '0;
    assign bank_wr_data_o   = bank_wr_vld_o ? new_q : '0;
    assign bank_wr_mask_o   = bank_wr_vld_o ? wr_mask : '0;
    assign rob_wb_vld_o     = (state_q == AMO_S_RESP);
    assign rob_wb_rob_tag_o = rob_wb_vld_o ? req_q.rob_tag : '0;
    assign rob_wb_prd_o     = rob_wb_vld_o ? req_q.prd : '0;
    assign rob_wb_data_o    = rob_wb_vld_o ? wb_data : '0;
`ifdef RVH_L1D_AMO_MISALIGN_CHK_EN
    assign rob_wb_excp_o    = rob_wb_vld_o & misalign_q;
`endif

    rd_resp_in_rd_wait: assert property (@(posedge clk) disable iff (!rst)
        bank_rd_resp_vld_i |-> (state_q == AMO_S_RD_WAIT));

endmodule

// File: tb/tb_rvh_l1d_amo_exec.sv
// tb/tb_rvh_l1d_amo_exec.sv - directed self-checking bench for rvh_l1d_amo_exec
module tb_rvh_l1d_amo_exec;
    import rvh_l1d_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        amo_req_vld_i, amo_req_rdy_o, amo_req_sc_succ_i;
    logic [6:0]  amo_req_rob_tag_i, amo_req_prd_i;
    logic [5:0]  amo_req_opcode_i;
    logic [55:0] amo_req_paddr_i;
    logic [63:0] amo_req_data_i;
    logic        bank_rd_vld_o, bank_rd_rdy_i, bank_rd_resp_vld_i;
    logic [55:0] bank_rd_addr_o;
    logic [63:0] bank_rd_resp_data_i;
    logic        bank_wr_vld_o, bank_wr_rdy_i;
    logic [55:0] bank_wr_addr_o;
    logic [63:0] bank_wr_data_o;
    logic [7:0]  bank_wr_mask_o;
    logic        rob_wb_vld_o;
    logic [6:0]  rob_wb_rob_tag_o, rob_wb_prd_o;
    logic [63:0] rob_wb_data_o;
`ifdef RVH_L1D_AMO_MISALIGN_CHK_EN
    logic        rob_wb_excp_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    int          rd_cnt, wr_cnt, wb_cnt, wb_lat;
    logic [55:0] rd_addr_s, wr_addr_s;
    logic [63:0] wr_data_s, wb_data_s;
    logic [7:0]  wr_mask_s;
    logic [6:0]  wb_tag_s, wb_prd_s;
    logic        wb_excp_s, rd_unstable, wr_unstable, rdy_early, wr_vld_after_rst;

    always #5 clk = ~clk;

    rvh_l1d_amo_exec dut (
        .clk(clk), .rst(rst),
        .amo_req_vld_i(amo_req_vld_i), .amo_req_rdy_o(amo_req_rdy_o),
        .amo_req_rob_tag_i(amo_req_rob_tag_i), .amo_req_prd_i(amo_req_prd_i),
        .amo_req_opcode_i(amo_req_opcode_i), .amo_req_paddr_i(amo_req_paddr_i),
        .amo_req_data_i(amo_req_data_i), .amo_req_sc_succ_i(amo_req_sc_succ_i),
        .bank_rd_vld_o(bank_rd_vld_o), .bank_rd_rdy_i(bank_rd_rdy_i),
        .bank_rd_addr_o(bank_rd_addr_o), .bank_rd_resp_vld_i(bank_rd_resp_vld_i),
        .bank_rd_resp_data_i(bank_rd_resp_data_i),
        .bank_wr_vld_o(bank_wr_vld_o), .bank_wr_rdy_i(bank_wr_rdy_i),
        .bank_wr_addr_o(bank_wr_addr_o), .bank_wr_data_o(bank_wr_data_o),
        .bank_wr_mask_o(bank_wr_mask_o),
        .rob_wb_vld_o(rob_wb_vld_o), .rob_wb_rob_tag_o(rob_wb_rob_tag_o),
        .rob_wb_prd_o(rob_wb_prd_o), .rob_wb_data_o(rob_wb_data_o)
`ifdef RVH_L1D_AMO_MISALIGN_CHK_EN
        , .rob_wb_excp_o(rob_wb_excp_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, then play the bank for 24 cycles (fixed bound) while recording what the DUT did.
    task automatic run_op(input logic [5:0] op, input logic [55:0] pa, input logic [63:0] rs2,
                          input logic succ, input logic [63:0] mem, input int rd_stall,
                          input int wr_stall, input bit rst_in_wr);
        int rs = rd_stall;
        int ws = wr_stall;
        bit rd_hs_prev = 0, rst_pending = 0, rst_req = rst_in_wr, rd_seen = 0, wr_seen = 0;
        rd_cnt = 0; wr_cnt = 0; wb_cnt = 0; wb_lat = 0;
        rd_addr_s = '0; wr_addr_s = '0; wr_data_s = '0; wr_mask_s = '0;
        wb_data_s = '0; wb_tag_s = '0; wb_prd_s = '0; wb_excp_s = 1'b0;
        rd_unstable = 0; wr_unstable = 0; rdy_early = 0; wr_vld_after_rst = 1'b1;
        @(negedge clk);
        amo_req_vld_i = 1'b1; amo_req_opcode_i = op; amo_req_paddr_i = pa;
        amo_req_data_i = rs2; amo_req_sc_succ_i = succ;
        amo_req_rob_tag_i = 7'(op) + 7'd3; amo_req_prd_i = 7'(op) ^ 7'h40;
        @(negedge clk);
        amo_req_vld_i = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (rst_pending) begin
                wr_vld_after_rst = bank_wr_vld_o; rst = 1'b1; rst_pending = 0;
            end
            bank_rd_resp_vld_i  = rd_hs_prev;
            bank_rd_resp_data_i = rd_hs_prev ? mem : 64'd0;
            rd_hs_prev = 0;
            if (rob_wb_vld_o) begin
                wb_cnt++;
                if (wb_cnt == 1) begin
                    wb_lat = k + 1; wb_data_s = rob_wb_data_o;
                    wb_tag_s = rob_wb_rob_tag_o; wb_prd_s = rob_wb_prd_o;
`ifdef RVH_L1D_AMO_MISALIGN_CHK_EN
                    wb_excp_s = rob_wb_excp_o;
`endif
                end
            end
            if (wb_cnt == 0 && amo_req_rdy_o) rdy_early = 1;
            bank_rd_rdy_i = 1'b0;
            if (bank_rd_vld_o) begin
                if (!rd_seen) begin rd_addr_s = bank_rd_addr_o; rd_seen = 1; end
                else if (bank_rd_addr_o !== rd_addr_s) rd_unstable = 1;
                if (rs > 0) rs--;
                else begin bank_rd_rdy_i = 1'b1; rd_cnt++; rd_hs_prev = 1; end
            end
            bank_wr_rdy_i = 1'b0;
            if (bank_wr_vld_o) begin
                if (!wr_seen) begin
                    wr_addr_s = bank_wr_addr_o; wr_data_s = bank_wr_data_o;
                    wr_mask_s = bank_wr_mask_o; wr_seen = 1;
                end else if (bank_wr_addr_o !== wr_addr_s || bank_wr_data_o !== wr_data_s ||
                             bank_wr_mask_o !== wr_mask_s) wr_unstable = 1;
                if (rst_req) begin rst = 1'b0; rst_pending = 1; rst_req = 0; end
                else if (ws > 0) ws--;
                else begin bank_wr_rdy_i = 1'b1; wr_cnt++; end
            end
            @(negedge clk);
        end
        bank_rd_rdy_i = 1'b0; bank_wr_rdy_i = 1'b0; bank_rd_resp_vld_i = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; amo_req_vld_i = 1'b0; amo_req_sc_succ_i = 1'b0;
        amo_req_rob_tag_i = '0; amo_req_prd_i = '0; amo_req_opcode_i = '0;
        amo_req_paddr_i = '0; amo_req_data_i = '0;
        bank_rd_rdy_i = 1'b0; bank_rd_resp_vld_i = 1'b0; bank_rd_resp_data_i = '0;
        bank_wr_rdy_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_rdy",  64'(amo_req_rdy_o), 64'd1);
        chk("rst_rd_vld",   64'(bank_rd_vld_o), 64'd0);
        chk("rst_rd_addr",  64'(bank_rd_addr_o), 64'd0);
        chk("rst_wr_vld",   64'(bank_wr_vld_o), 64'd0);
        chk("rst_wr_mask",  64'(bank_wr_mask_o), 64'd0);
        chk("rst_wb_vld",   64'(rob_wb_vld_o), 64'd0);
        chk("rst_wb_data",  rob_wb_data_o, 64'd0);
        rst = 1'b1;

        run_op(STU_AMOADDW, 56'h00_0000_8000_1004, 64'd1, 1'b0, 64'h7FFF_FFFF_0000_0000, 0, 0, 0);
        chk("addw_rd_addr", 64'(rd_addr_s), 64'h0000_0000_8000_1000);
        chk("addw_wr_addr", 64'(wr_addr_s), 64'h0000_0000_8000_1000);
        chk("addw_wr_data", wr_data_s, 64'h8000_0000_8000_0000);
        chk("addw_wr_mask", 64'(wr_mask_s), 64'h0000_0000_0000_00F0);
        chk("addw_wb_data", wb_data_s, 64'h0000_0000_7FFF_FFFF);
        chk("addw_wb_cnt",  64'(wb_cnt), 64'd1);
        chk("addw_latency", 64'(wb_lat), 64'd6);
        chk("addw_wb_tag",  64'(wb_tag_s), 64'(7'(STU_AMOADDW) + 7'd3));
        chk("addw_wb_prd",  64'(wb_prd_s), 64'(7'(STU_AMOADDW) ^ 7'h40));
`ifdef RVH_L1D_AMO_MISALIGN_CHK_EN
        chk("addw_excp",    64'(wb_excp_s), 64'd0);
`endif

        run_op(STU_AMOMAXD, 56'h00_0000_2000_0008, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        chk("maxd_wr_data", wr_data_s, 64'd0);
        chk("maxd_wr_mask", 64'(wr_mask_s), 64'h0000_0000_0000_00FF);
        chk("maxd_wb_data", wb_data_s, 64'hFFFF_FFFF_FFFF_FFFF);

        run_op(STU_AMOMAXUD, 56'h00_0000_2000_0008, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        chk("maxud_wr_data", wr_data_s, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("maxud_wb_data", wb_data_s, 64'hFFFF_FFFF_FFFF_FFFF);

        run_op(STU_SCD, 56'h00_0000_3000_0010, 64'd5, 1'b0, 64'h0, 0, 0, 0);
        chk("scfail_rd_cnt",  64'(rd_cnt), 64'd0);
        chk("scfail_wr_cnt",  64'(wr_cnt), 64'd0);
        chk("scfail_wb_data", wb_data_s, 64'd1);
        chk("scfail_latency", 64'(wb_lat), 64'd2);
        chk("scfail_wb_cnt",  64'(wb_cnt), 64'd1);

        run_op(STU_SCD, 56'h00_0000_3000_0010, 64'd5, 1'b1, 64'h1234, 0, 0, 0);
        chk("scok_wr_cnt",  64'(wr_cnt), 64'd1);
        chk("scok_wr_data", wr_data_s, 64'd5);
        chk("scok_wr_mask", 64'(wr_mask_s), 64'h0000_0000_0000_00FF);
        chk("scok_wb_data", wb_data_s, 64'd0);

        run_op(STU_LRW, 56'h00_0000_4000_0000, 64'd0, 1'b0, 64'hDEAD_BEEF_8000_0001, 0, 0, 0);
        chk("lrw_wr_cnt",  64'(wr_cnt), 64'd0);
        chk("lrw_wb_data", wb_data_s, 64'hFFFF_FFFF_8000_0001);
        chk("lrw_latency", 64'(wb_lat), 64'd5);

        run_op(STU_AMOSWAPD, 56'h00_0000_5000_0018, 64'hCAFE_F00D_1234_5678, 1'b0,
               64'h0123_4567_89AB_CDEF, 4, 4, 0);
        chk("stall_rd_stable", 64'(rd_unstable), 64'd0);
        chk("stall_wr_stable", 64'(wr_unstable), 64'd0);
        chk("stall_wb_cnt",    64'(wb_cnt), 64'd1);
        chk("stall_rdy_low",   64'(rdy_early), 64'd0);
        chk("stall_wr_data",   wr_data_s, 64'hCAFE_F00D_1234_5678);
        chk("stall_wb_data",   wb_data_s, 64'h0123_4567_89AB_CDEF);
        chk("stall_latency",   64'(wb_lat), 64'd14);

        run_op(STU_AMOMINW, 56'h00_0000_6000_0020, 64'd1, 1'b0, 64'h1234_5678_8000_0000, 0, 0, 0);
        chk("minw_wr_data", wr_data_s, 64'h8000_0000_8000_0000);
        chk("minw_wr_mask", 64'(wr_mask_s), 64'h0000_0000_0000_000F);
        chk("minw_wb_data", wb_data_s, 64'hFFFF_FFFF_8000_0000);

        run_op(STU_AMOMINUW, 56'h00_0000_6000_0020, 64'd1, 1'b0, 64'h1234_5678_8000_0000, 0, 0, 0);
        chk("minuw_wr_data", wr_data_s, 64'h0000_0001_0000_0001);

        run_op(STU_AMOXORW, 56'h00_0000_6000_002C, 64'hFFFF_FFFF_0FF0_0FF0, 1'b0,
               64'hF0F0_F0F0_0000_0000, 0, 0, 0);
        chk("xorw_wr_data", wr_data_s, 64'hFF00_FF00_FF00_FF00);
        chk("xorw_wr_mask", 64'(wr_mask_s), 64'h0000_0000_0000_00F0);
        chk("xorw_wb_data", wb_data_s, 64'hFFFF_FFFF_F0F0_F0F0);

        run_op(STU_AMOANDD, 56'h00_0000_7000_0000, 64'h0F0F, 1'b0, 64'hFFFF, 0, 10, 1);
        chk("rstwr_wr_vld", 64'(wr_vld_after_rst), 64'd0);
        chk("rstwr_wr_cnt", 64'(wr_cnt), 64'd0);
        chk("rstwr_wb_cnt", 64'(wb_cnt), 64'd0);
        chk("rstwr_rdy",    64'(amo_req_rdy_o), 64'd1);

        run_op(STU_AMOORD, 56'h00_0000_7000_0000, 64'h0F00, 1'b0, 64'h00F0, 0, 0, 0);
        chk("ord_wr_data", wr_data_s, 64'h0FF0);
        chk("ord_wb_data", wb_data_s, 64'h00F0);

`ifdef RVH_L1D_AMO_MISALIGN_CHK_EN
        run_op(STU_AMOSWAPD, 56'h00_0000_8000_0004, 64'h55, 1'b0, 64'h99, 0, 0, 0);
        chk("mis_excp",    64'(wb_excp_s), 64'd1);
        chk("mis_wb_data", wb_data_s, 64'd0);
        chk("mis_rd_cnt",  64'(rd_cnt), 64'd0);
        chk("mis_wr_cnt",  64'(wr_cnt), 64'd0);
`else
        run_op(STU_AMOSWAPD, 56'h00_0000_8000_0004, 64'h55, 1'b0, 64'h99, 0, 0, 0);
        chk("lowbits_rd_addr", 64'(rd_addr_s), 64'h0000_0000_8000_0000);
        chk("lowbits_wr_data", wr_data_s, 64'h55);
        chk("lowbits_wb_data", wb_data_s, 64'h99);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
